// File: rtl/mul_share_arb.sv
// mul_share_arb: shares one pipelined 33x33 booth_walloc multiplier between
// NREQ requesters. Each port has its own response FIFO and credit count, so the
// multiplier's non-stallable output always has a slot waiting for it.
// Optional feature macro: MUL_ARB_RR_EN (round-robin grant). When it is not
// defined, the grant uses fixed priority and the lowest index wins.

// Two-stage multiplier: operands are registered on accept, and the product is
// registered one edge later. in_ready stays low for the first cycle after reset.
module booth_walloc (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [32:0] src1,
    input  logic [32:0] src2,
    output logic        first_doing,
    output logic        out_valid,
    output logic [63:0] result
);
    logic               rdy_q;
    logic               s1_vld_q;
    logic               out_vld_q;
    logic signed [32:0] s1_a_q;
    logic signed [32:0] s1_b_q;
    logic        [63:0] res_q;
    logic        [63:0] prod_s;

    // Pipeline valid bits and the startup hold on in_ready
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q     <= 1'b0;
            s1_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            rdy_q     <= 1'b1;
            s1_vld_q  <= in_valid & rdy_q;
            out_vld_q <= s1_vld_q;
        end
    end

    // Low 64 bits of the sign-extended product are exact for both operand modes
    always_comb begin
        prod_s = 64'(s1_a_q) * 64'(s1_b_q);
    end

    // Datapath registers; they are qualified by the valid bits, so they have no reset
    always_ff @(posedge clk) begin
        s1_a_q <= src1;
        s1_b_q <= src2;
        res_q  <= prod_s;
    end

    assign in_ready    = rdy_q;
    assign first_doing = s1_vld_q;
    assign out_valid   = out_vld_q;
    assign result      = res_q;
endmodule

// Simulation checks on the arbiter's internal bookkeeping
module mul_share_arb_chk #(
    parameter int NREQ = 2
) (
    input logic            clk_i,
    input logic            reset_i,
    input logic [NREQ-1:0] wr_i,
    input logic [NREQ-1:0] pop_i,
    input logic [NREQ-1:0] full_i,
    input logic            tag0_vld_i,
    input logic            first_doing_i,
    input logic            tag1_vld_i,
    input logic            out_valid_i
);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        ((wr_i & full_i & ~pop_i) == {NREQ{1'b0}}));
    a_tag_align: assert property (@(posedge clk_i) disable iff (reset_i)
        ((tag0_vld_i == first_doing_i) && (tag1_vld_i == out_valid_i)));
endmodule

module mul_share_arb #(
    parameter int NREQ       = 2,
    parameter int RESP_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ-1:0]      req_signed,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [NREQ*64-1:0]   resp_data
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = 3;

    logic [63:0]      mem_q    [NREQ][RESP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [NREQ];
    logic [PTR_W-1:0] wr_ptr_d [NREQ];
    logic [PTR_W-1:0] rd_ptr_q [NREQ];
    logic [PTR_W-1:0] rd_ptr_d [NREQ];
    logic [CNT_W-1:0] cnt_q    [NREQ];
    logic [CNT_W-1:0] cnt_d    [NREQ];
    logic [CNT_W-1:0] infl_q   [NREQ];
    logic [CNT_W-1:0] infl_d   [NREQ];
    logic [1:0]       tag_vld_q;
    logic [ID_W-1:0]  tag_id_q [2];

    logic [NREQ-1:0]  elig_s;
    logic [NREQ-1:0]  gnt_s;
    logic [NREQ-1:0]  wr_s;
    logic [NREQ-1:0]  pop_s;
    logic [NREQ-1:0]  full_s;
    logic             any_gnt_s;
    logic [ID_W-1:0]  gnt_id_s;
    logic [32:0]      mul_a_s;
    logic [32:0]      mul_b_s;
    logic             mul_in_ready_s;
    logic             mul_first_s;
    logic             mul_out_valid_s;
    logic [63:0]      mul_res_s;

    // Circular-buffer pointer advance with wrap at RESP_DEPTH
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RESP_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // A port may issue only when it has a free response slot and the multiplier can take it
    always_comb begin
        elig_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && mul_in_ready_s &&
                ((4'(cnt_q[i]) + 4'(infl_q[i])) < 4'(RESP_DEPTH))) begin
                elig_s[i] = 1'b1;
            end else begin
                elig_s[i] = 1'b0;
            end
        end
    end

`ifdef MUL_ARB_RR_EN
    logic [ID_W-1:0] rr_q;
    logic [ID_W-1:0] rr_d;
    int              best_v;
    int              dist_v;

    // Round-robin pick: the eligible port closest after the last granted one
    always_comb begin
        any_gnt_s = 1'b0;
        gnt_id_s  = {ID_W{1'b0}};
        best_v    = NREQ;
        dist_v    = 0;
        for (int i = 0; i < NREQ; i++) begin
            dist_v = i - int'(rr_q) - 1;
            if (dist_v < 0) begin
                dist_v = dist_v + NREQ;
            end else begin
                dist_v = dist_v;
            end
            if (elig_s[i] && (dist_v < best_v)) begin
                best_v    = dist_v;
                any_gnt_s = 1'b1;
                gnt_id_s  = ID_W'(i);
            end else begin
                best_v    = best_v;
            end
        end
        if (any_gnt_s) begin
            rr_d = gnt_id_s;
        end else begin
            rr_d = rr_q;
        end
    end

    // Pointer moves only on a grant; reset leaves port 0 with first priority
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= ID_W'(NREQ - 1);
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Fixed priority: the lowest eligible index wins
    always_comb begin
        any_gnt_s = 1'b0;
        gnt_id_s  = {ID_W{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (elig_s[i]) begin
                any_gnt_s = 1'b1;
                gnt_id_s  = ID_W'(i);
            end else begin
                any_gnt_s = any_gnt_s;
            end
        end
    end
`endif

    // One-hot grant vector and the operand mux, with 33-bit extension for the sign mode
    always_comb begin
        gnt_s   = {NREQ{1'b0}};
        mul_a_s = 33'd0;
        mul_b_s = 33'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (any_gnt_s && (gnt_id_s == ID_W'(i))) begin
                gnt_s[i] = 1'b1;
                if (req_signed[i]) begin
                    mul_a_s = {req_a[32*i+31], req_a[32*i +: 32]};
                    mul_b_s = {req_b[32*i+31], req_b[32*i +: 32]};
                end else begin
                    mul_a_s = {1'b0, req_a[32*i +: 32]};
                    mul_b_s = {1'b0, req_b[32*i +: 32]};
                end
            end else begin
                gnt_s[i] = 1'b0;
            end
        end
    end

    assign req_ready = gnt_s;

    booth_walloc u_mul (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (any_gnt_s),
        .in_ready    (mul_in_ready_s),
        .src1        (mul_a_s),
        .src2        (mul_b_s),
        .first_doing (mul_first_s),
        .out_valid   (mul_out_valid_s),
        .result      (mul_res_s)
    );

    // Tag pipeline tracks which port owns each product in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld_q   <= 2'b00;
            tag_id_q[0] <= {ID_W{1'b0}};
            tag_id_q[1] <= {ID_W{1'b0}};
        end else begin
            tag_vld_q   <= {tag_vld_q[0], any_gnt_s};
            tag_id_q[0] <= gnt_id_s;
            tag_id_q[1] <= tag_id_q[0];
        end
    end

    // Per-port write/pop strobes and the next-state of counts, credits and pointers
    always_comb begin
        wr_s   = {NREQ{1'b0}};
        pop_s  = {NREQ{1'b0}};
        full_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            wr_s[i]     = mul_out_valid_s && tag_vld_q[1] && (tag_id_q[1] == ID_W'(i));
            pop_s[i]    = (cnt_q[i] != CNT_W'(0)) && resp_ready[i];
            full_s[i]   = (cnt_q[i] == CNT_W'(RESP_DEPTH));
            cnt_d[i]    = cnt_q[i];
            infl_d[i]   = infl_q[i];
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            case ({wr_s[i], pop_s[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
            case ({gnt_s[i], wr_s[i]})
                2'b10:   infl_d[i] = infl_q[i] + CNT_W'(1);
                2'b01:   infl_d[i] = infl_q[i] - CNT_W'(1);
                default: infl_d[i] = infl_q[i];
            endcase
            if (wr_s[i]) begin
                wr_ptr_d[i] = next_ptr(wr_ptr_q[i]);
            end else begin
                wr_ptr_d[i] = wr_ptr_q[i];
            end
            if (pop_s[i]) begin
                rd_ptr_d[i] = next_ptr(rd_ptr_q[i]);
            end else begin
                rd_ptr_d[i] = rd_ptr_q[i];
            end
        end
    end

    // Count, credit and pointer registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (reset) begin
                cnt_q[i]    <= {CNT_W{1'b0}};
                infl_q[i]   <= {CNT_W{1'b0}};
                wr_ptr_q[i] <= {PTR_W{1'b0}};
                rd_ptr_q[i] <= {PTR_W{1'b0}};
            end else begin
                cnt_q[i]    <= cnt_d[i];
                infl_q[i]   <= infl_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
        end
    end

    // FIFO storage is not reset; the head output is gated by the count instead
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (wr_s[i]) begin
                mem_q[i][wr_ptr_q[i]] <= mul_res_s;
            end
        end
    end

    // Head-of-FIFO presentation, driven from registered state only
    always_comb begin
        resp_valid = {NREQ{1'b0}};
        resp_data  = {(NREQ*64){1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (cnt_q[i] != CNT_W'(0)) begin
                resp_valid[i]         = 1'b1;
                resp_data[64*i +: 64] = mem_q[i][rd_ptr_q[i]];
            end else begin
                resp_valid[i]         = 1'b0;
                resp_data[64*i +: 64] = 64'd0;
            end
        end
    end

    mul_share_arb_chk #(.NREQ(NREQ)) u_chk (
        .clk_i         (clk),
        .reset_i       (reset),
        .wr_i          (wr_s),
        .pop_i         (pop_s),
        .full_i        (full_s),
        .tag0_vld_i    (tag_vld_q[0]),
        .first_doing_i (mul_first_s),
        .tag1_vld_i    (tag_vld_q[1]),
        .out_valid_i   (mul_out_valid_s)
    );
endmodule
